// File: rtl/fifo_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and future read-side scheduler.
package fifo_arbiter_pkg;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    // Modulo increment that stays correct when count is not a power of two.
    function automatic int unsigned rotate_index(input int unsigned index, input int unsigned count);
        return (index + 1 >= count) ? 0 : index + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority encoder: first set bit of valid, scanning from rr_pointer upward with wrap.
module rr_picker #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] rr_pointer,
    output logic            found,
    output logic [ID_W-1:0] index
);

    int unsigned w_cand;

    always_comb begin
        found  = 1'b0;
        index  = '0;
        w_cand = 0;
        for (int unsigned off = 0; off < N; off++) begin
            w_cand = 32'(rr_pointer) + off;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!found && valid[w_cand[ID_W-1:0]]) begin
                found = 1'b1;
                index = w_cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one dual-clock FIFO's write port among several producers.
// Define FIFO_WRITE_ARBITER_SOURCE_TAG_EN to prepend grant_id to every written word.
module fifo_write_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter  int unsigned WIDTH      = 8,
    parameter  int unsigned LENGTH     = 16,
    parameter  int unsigned REQUESTERS = 4,
    parameter  int unsigned MAX_BURST  = 8,
    localparam int unsigned ID_WIDTH   = $clog2(REQUESTERS),
    localparam int unsigned USED_WIDTH = $clog2(LENGTH),
`ifdef FIFO_WRITE_ARBITER_SOURCE_TAG_EN
    localparam int unsigned FIFO_WIDTH = WIDTH + ID_WIDTH
`else
    localparam int unsigned FIFO_WIDTH = WIDTH
`endif
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [REQUESTERS-1:0]            request_valid,
    input  logic [REQUESTERS-1:0]            request_last,
    input  logic [REQUESTERS-1:0][WIDTH-1:0] request_data,
    output logic [REQUESTERS-1:0]            request_ready,
    input  logic [USED_WIDTH-1:0]            fifo_data_in_used,
    output logic                             fifo_data_in_enable,
    output logic [FIFO_WIDTH-1:0]            fifo_data_in,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic                             busy
);

    localparam int unsigned           BEAT_WIDTH = $clog2(MAX_BURST + 1);
    localparam logic [USED_WIDTH-1:0] FULL_LEVEL = USED_WIDTH'(LENGTH - 1);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT  = BEAT_WIDTH'(MAX_BURST - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ID_WIDTH-1:0]   r_rr_pointer;
    logic [ID_WIDTH-1:0]   w_next_rr_pointer;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic [ID_WIDTH-1:0]   w_next_grant_id;
    logic [BEAT_WIDTH-1:0] r_beat_count;
    logic [BEAT_WIDTH-1:0] w_next_beat_count;
    logic                  w_space;
    logic                  w_transfer;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_pick;

    // The FIFO's own accept rule; its count lags a write by one cycle, which keeps full-rate writes exact.
    assign w_space  = fifo_data_in_used < FULL_LEVEL;
    assign grant_id = r_grant_id;

    rr_picker #(
        .N    (REQUESTERS),
        .ID_W (ID_WIDTH)
    ) u_rr_picker (
        .valid      (request_valid),
        .rr_pointer (r_rr_pointer),
        .found      (w_found),
        .index      (w_pick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_rr_pointer <= '0;
            r_grant_id   <= '0;
            r_beat_count <= '0;
        end else begin
            r_state      <= w_next_state;
            r_rr_pointer <= w_next_rr_pointer;
            r_grant_id   <= w_next_grant_id;
            r_beat_count <= w_next_beat_count;
        end
    end

    always_comb begin
        w_next_state        = r_state;
        w_next_rr_pointer   = r_rr_pointer;
        w_next_grant_id     = r_grant_id;
        w_next_beat_count   = r_beat_count;
        w_transfer          = 1'b0;
        request_ready       = '0;
        fifo_data_in_enable = 1'b0;
        fifo_data_in        = '0;
        busy                = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state      = GRANTED;
                    w_next_grant_id   = w_pick;
                    w_next_beat_count = '0;
                end
            end
            GRANTED: begin
                busy                      = 1'b1;
                request_ready[r_grant_id] = w_space;
                w_transfer                = request_valid[r_grant_id] && w_space;
                fifo_data_in_enable       = w_transfer;
`ifdef FIFO_WRITE_ARBITER_SOURCE_TAG_EN
                fifo_data_in              = {r_grant_id, request_data[r_grant_id]};
`else
                fifo_data_in              = request_data[r_grant_id];
`endif
                if (w_transfer) begin
                    w_next_beat_count = r_beat_count + 1'b1;
                end
                // A full FIFO blocks both transfer and the valid-drop release, so the grant is held.
                if ((w_transfer && (request_last[r_grant_id] || r_beat_count == LAST_BEAT)) ||
                    (!request_valid[r_grant_id] && w_space)) begin
                    w_next_state      = IDLE;
                    w_next_rr_pointer = ID_WIDTH'(rotate_index(32'(r_grant_id), REQUESTERS));
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized check of fifo_write_arbiter against a transaction-level model of its grant rules.
module tb_fifo_write_arbiter;

    localparam int R   = 4;
    localparam int W   = 8;
    localparam int LEN = 16;
    localparam int MB  = 8;
    localparam int IDW = 2;
`ifdef FIFO_WRITE_ARBITER_SOURCE_TAG_EN
    localparam int FW  = W + IDW;
`else
    localparam int FW  = W;
`endif

    logic                  clock;
    logic                  reset_n;
    logic [R-1:0]          request_valid;
    logic [R-1:0]          request_last;
    logic [R-1:0][W-1:0]   request_data;
    logic [R-1:0]          request_ready;
    logic [3:0]            fifo_data_in_used;
    logic                  fifo_data_in_enable;
    logic [FW-1:0]         fifo_data_in;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    int total = 0;
    int bad   = 0;

    // Model: who owns the port (-1 = nobody), where the next search starts, beats taken, last grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_grant = 0;

    logic         fix_data = 1'b0;
    logic [W-1:0] fix_val  = '0;
    int           n_en     = 0;

    fifo_write_arbiter #(
        .WIDTH      (W),
        .LENGTH     (LEN),
        .REQUESTERS (R),
        .MAX_BURST  (MB)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .request_valid       (request_valid),
        .request_last        (request_last),
        .request_data        (request_data),
        .request_ready       (request_ready),
        .fifo_data_in_used   (fifo_data_in_used),
        .fifo_data_in_enable (fifo_data_in_enable),
        .fifo_data_in        (fifo_data_in),
        .grant_id            (grant_id),
        .busy                (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit            sp;
        logic [R-1:0]  e_ready;
        logic          e_en;
        logic [FW-1:0] e_data;
        sp      = int'(fifo_data_in_used) < LEN - 1;
        e_ready = '0;
        e_en    = 1'b0;
        e_data  = '0;
        if (m_owner >= 0) begin
            e_ready[m_owner] = sp;
            e_en             = request_valid[m_owner] && sp;
`ifdef FIFO_WRITE_ARBITER_SOURCE_TAG_EN
            e_data           = {IDW'(m_owner), request_data[m_owner]};
`else
            e_data           = request_data[m_owner];
`endif
        end
        chk("ready",  request_ready, e_ready);
        chk("enable", fifo_data_in_enable, e_en);
        chk("data",   fifo_data_in, e_data);
        chk("busy",   busy, m_owner >= 0);
        chk("grant",  grant_id, m_grant);
        chk("en_without_ready", fifo_data_in_enable && !request_ready[grant_id], 1'b0);
        if (fifo_data_in_enable) n_en++;
    endtask

    task automatic model_step();
        bit sp;
        bit xfer;
        sp = int'(fifo_data_in_used) < LEN - 1;
        if (m_owner < 0) begin
            for (int k = 0; k < R; k++) begin
                int c;
                c = (m_ptr + k) % R;
                if (m_owner < 0 && request_valid[c]) begin
                    m_owner = c;
                    m_grant = c;
                    m_beats = 0;
                end
            end
        end else begin
            xfer = request_valid[m_owner] && sp;
            if (xfer) m_beats++;
            if ((xfer && (request_last[m_owner] || m_beats == MB)) || (!request_valid[m_owner] && sp)) begin
                m_ptr   = (m_owner + 1) % R;
                m_owner = -1;
            end
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_grant = 0;
    endtask

    task automatic cycle(input logic [R-1:0] v, input logic [R-1:0] l, input logic [3:0] used);
        @(negedge clock);
        request_valid     = v;
        request_last      = l;
        fifo_data_in_used = used;
        for (int r = 0; r < R; r++) request_data[r] = fix_data ? fix_val : W'($urandom);
        #1;
        check_outputs();
        model_step();
    endtask

    initial begin
        reset_n           = 1'b0;
        request_valid     = '0;
        request_last      = '0;
        fifo_data_in_used = '0;
        for (int r = 0; r < R; r++) request_data[r] = W'($urandom);

        // Reset state, with nonzero payload on the inputs to show the data gating.
        repeat (2) @(negedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;

        // Reset mid-burst: grant requester 0, take 3 beats, then reset asynchronously.
        cycle(4'b0001, 4'b0000, 4'd0);
        repeat (3) cycle(4'b0001, 4'b0000, 4'd0);
        @(negedge clock);
        #2;
        request_valid = '0;
        reset_n       = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;

        // All requesters valid: rotating service 0,1,2,3,0 in full MAX_BURST bursts.
        repeat (42) cycle(4'b1111, 4'b0000, 4'd3);
        cycle(4'b0000, 4'b0000, 4'd0);
        cycle(4'b0000, 4'b0000, 4'd0);

        // Requesters 0 and 2 continuously valid, never last.
        repeat (30) cycle(4'b0101, 4'b0000, 4'd0);
        cycle(4'b0000, 4'b0000, 4'd0);
        cycle(4'b0000, 4'b0000, 4'd0);

        // Requester 1: three beats, last on the third.
        n_en = 0;
        cycle(4'b0010, 4'b0000, 4'd0);
        cycle(4'b0010, 4'b0000, 4'd0);
        cycle(4'b0010, 4'b0000, 4'd0);
        cycle(4'b0010, 4'b0010, 4'd0);
        cycle(4'b0000, 4'b0000, 4'd0);
        cycle(4'b0000, 4'b0000, 4'd0);
        chk("req1_beat_count", n_en, 3);
        cycle(4'b1111, 4'b0000, 4'd0);
        cycle(4'b1111, 4'b0000, 4'd0);
        chk("rr_after_last", grant_id, 2'd2);
        cycle(4'b0000, 4'b0000, 4'd0);
        cycle(4'b0000, 4'b0000, 4'd0);

        // FIFO full while granted: grant held, no writes; 14 resumes at once.
        cycle(4'b0001, 4'b0000, 4'd0);
        cycle(4'b0001, 4'b0000, 4'd0);
        repeat (4) cycle(4'b0001, 4'b0000, 4'd15);
        chk("full_hold_busy", busy, 1'b1);
        cycle(4'b0001, 4'b0000, 4'd14);
        chk("resume_enable", fifo_data_in_enable, 1'b1);
        cycle(4'b0000, 4'b0000, 4'd15);
        chk("full_hold_no_release", busy, 1'b1);
        cycle(4'b0000, 4'b0000, 4'd0);
        cycle(4'b0000, 4'b0000, 4'd0);

`ifdef FIFO_WRITE_ARBITER_SOURCE_TAG_EN
        fix_data = 1'b1;
        fix_val  = 8'hA5;
        cycle(4'b1000, 4'b0000, 4'd0);
        cycle(4'b1000, 4'b0000, 4'd0);
        chk("tag_a5", fifo_data_in, 10'b11_1010_0101);
        cycle(4'b0000, 4'b0000, 4'd0);
        cycle(4'b0000, 4'b0000, 4'd0);
        fix_data = 1'b0;
`endif

        // Randomized traffic with occasional full FIFO.
        for (int i = 0; i < 400; i++) begin
            logic [R-1:0] v;
            logic [R-1:0] l;
            logic [3:0]   u;
            v = R'($urandom_range(0, 15));
            l = R'($urandom & $urandom);
            u = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            cycle(v, l, u);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
